// File: rtl/pdn_rail_sequencer.sv
// Power rail sequencer: ramps rails up in index order with power-good and settle
// handshakes, ramps down in reverse, and latches a fault on timeout or power-good loss.
module pdn_rail_sequencer #(
    parameter int unsigned NUM_RAILS = 8,
    parameter int unsigned TMR_W     = 16,
    parameter int unsigned IDX_W     = $clog2(NUM_RAILS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 pwr_on_req,
    input  logic                 fault_clr,
    input  logic [NUM_RAILS-1:0] rail_pg,
    input  logic [TMR_W-1:0]     settle_cycles,
    input  logic [TMR_W-1:0]     timeout_cycles,
    output logic [NUM_RAILS-1:0] rail_en,
    output logic                 all_good,
    output logic                 busy,
    output logic                 fault,
    output logic [IDX_W-1:0]     fault_rail
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_RAILS - 1);
    localparam logic [TMR_W-1:0] TMR_MAX  = {TMR_W{1'b1}};

    typedef enum logic [2:0] {
        ST_OFF    = 3'd0,
        ST_UP     = 3'd1,
        ST_SETTLE = 3'd2,
        ST_ON     = 3'd3,
        ST_DOWN   = 3'd4,
        ST_FAULT  = 3'd5
    } state_t;

    state_t                 state, state_nxt;
    logic [IDX_W-1:0]       idx, idx_nxt;
    logic [TMR_W-1:0]       timer, timer_nxt, timer_inc;
    logic [NUM_RAILS-1:0]   rail_en_nxt;
    logic [IDX_W-1:0]       fault_rail_nxt;
    logic                   all_good_nxt, busy_nxt, fault_nxt;
    logic                   supervised, loss;
    logic [IDX_W-1:0]       loss_rail;

    assign timer_inc  = (timer == TMR_MAX) ? timer : timer + TMR_W'(1);
    assign supervised = (state == ST_UP) || (state == ST_SETTLE) || (state == ST_ON);

    // Lowest confirmed rail whose power-good has dropped.
    always_comb begin
        loss      = 1'b0;
        loss_rail = '0;
        for (int j = int'(NUM_RAILS) - 1; j >= 0; j--) begin
            if (supervised && !rail_pg[j] &&
                ((IDX_W'(j) < idx) || ((IDX_W'(j) == idx) && (state != ST_UP)))) begin
                loss      = 1'b1;
                loss_rail = IDX_W'(j);
            end
        end
    end

    always_comb begin
        state_nxt      = state;
        idx_nxt        = idx;
        timer_nxt      = timer;
        rail_en_nxt    = rail_en;
        fault_rail_nxt = fault_rail;

        if (loss) begin
            state_nxt      = ST_FAULT;
            rail_en_nxt    = '0;
            fault_rail_nxt = loss_rail;
        end else begin
            case (state)
                ST_OFF: begin
                    if (pwr_on_req) begin
                        state_nxt   = ST_UP;
                        idx_nxt     = '0;
                        timer_nxt   = '0;
                        rail_en_nxt = NUM_RAILS'(1);
                    end
                end
                ST_UP: begin
                    if (!pwr_on_req) begin
                        state_nxt        = ST_DOWN;
                        timer_nxt        = '0;
                        rail_en_nxt[idx] = 1'b0;
                    end else if (rail_pg[idx]) begin
                        state_nxt = ST_SETTLE;
                        timer_nxt = '0;
                    end else if (timer >= timeout_cycles) begin
                        state_nxt      = ST_FAULT;
                        rail_en_nxt    = '0;
                        fault_rail_nxt = idx;
                    end else begin
                        timer_nxt = timer_inc;
                    end
                end
                ST_SETTLE: begin
                    if (!pwr_on_req) begin
                        state_nxt        = ST_DOWN;
                        timer_nxt        = '0;
                        rail_en_nxt[idx] = 1'b0;
                    end else if (timer == settle_cycles) begin
                        timer_nxt = '0;
                        if (idx == LAST_IDX) begin
                            state_nxt = ST_ON;
                        end else begin
                            state_nxt                       = ST_UP;
                            idx_nxt                         = idx + IDX_W'(1);
                            rail_en_nxt[idx + IDX_W'(1)]    = 1'b1;
                        end
                    end else begin
                        timer_nxt = timer_inc;
                    end
                end
                ST_ON: begin
                    if (!pwr_on_req) begin
                        state_nxt        = ST_DOWN;
                        timer_nxt        = '0;
                        rail_en_nxt[idx] = 1'b0;
                    end
                end
                ST_DOWN: begin
                    // A down-step timeout just moves on; rails are being removed anyway.
                    if (!rail_pg[idx] || (timer >= timeout_cycles)) begin
                        timer_nxt = '0;
                        if (idx == '0) begin
                            state_nxt = ST_OFF;
                        end else begin
                            idx_nxt                      = idx - IDX_W'(1);
                            rail_en_nxt[idx - IDX_W'(1)] = 1'b0;
                        end
                    end else begin
                        timer_nxt = timer_inc;
                    end
                end
                ST_FAULT: begin
                    rail_en_nxt = '0;
                    if (fault_clr && !pwr_on_req) begin
                        state_nxt      = ST_OFF;
                        idx_nxt        = '0;
                        timer_nxt      = '0;
                        fault_rail_nxt = '0;
                    end
                end
                default: begin
                    state_nxt      = ST_OFF;
                    idx_nxt        = '0;
                    timer_nxt      = '0;
                    rail_en_nxt    = '0;
                    fault_rail_nxt = '0;
                end
            endcase
        end

        all_good_nxt = (state_nxt == ST_ON);
        busy_nxt     = (state_nxt == ST_UP) || (state_nxt == ST_SETTLE) || (state_nxt == ST_DOWN);
        fault_nxt    = (state_nxt == ST_FAULT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_OFF;
            idx        <= '0;
            timer      <= '0;
            rail_en    <= '0;
            fault_rail <= '0;
            all_good   <= 1'b0;
            busy       <= 1'b0;
            fault      <= 1'b0;
        end else begin
            state      <= state_nxt;
            idx        <= idx_nxt;
            timer      <= timer_nxt;
            rail_en    <= rail_en_nxt;
            fault_rail <= fault_rail_nxt;
            all_good   <= all_good_nxt;
            busy       <= busy_nxt;
            fault      <= fault_nxt;
        end
    end

endmodule

// File: tb/tb_pdn_rail_sequencer.sv
// Bench for pdn_rail_sequencer: a rail plant with 2-cycle power-good lag, a phase/count
// model of the sequencing rules checked every cycle, and hand-computed directed checks.
module tb_pdn_rail_sequencer;

    localparam int NR = 4;
    localparam int TW = 16;
    localparam int IW = 2;

    localparam int P_OFF  = 0;
    localparam int P_RAMP = 1;
    localparam int P_HOLD = 2;
    localparam int P_ON   = 3;
    localparam int P_DOWN = 4;
    localparam int P_FLT  = 5;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          pwr_on_req = 1'b0;
    logic          fault_clr = 1'b0;
    logic [NR-1:0] rail_pg;
    logic [TW-1:0] settle_cycles = 16'd3;
    logic [TW-1:0] timeout_cycles = 16'd10;
    logic [NR-1:0] rail_en;
    logic          all_good, busy, fault;
    logic [IW-1:0] fault_rail;

    logic [NR-1:0] plant_d1 = '0;
    logic [NR-1:0] plant_pg = '0;
    logic [NR-1:0] stuck_low = '0;
    logic [NR-1:0] force_low = '0;

    int n_checks = 0;
    int n_errors = 0;

    int m_ph = P_OFF, m_cur = 0, m_cnt = 0, m_frail = 0;

    pdn_rail_sequencer #(.NUM_RAILS(NR), .TMR_W(TW), .IDX_W(IW)) dut (
        .clk            (clk),
        .rst            (rst),
        .pwr_on_req     (pwr_on_req),
        .fault_clr      (fault_clr),
        .rail_pg        (rail_pg),
        .settle_cycles  (settle_cycles),
        .timeout_cycles (timeout_cycles),
        .rail_en        (rail_en),
        .all_good       (all_good),
        .busy           (busy),
        .fault          (fault),
        .fault_rail     (fault_rail)
    );

    always #5 clk = ~clk;

    // Rail plant: power-good follows the enable two cycles later, with fault overrides.
    always @(negedge clk) begin
        plant_pg <= plant_d1;
        plant_d1 <= rail_en;
    end
    assign rail_pg = plant_pg & ~stuck_low & ~force_low;

    function automatic logic [NR-1:0] low_mask(input int k);
        logic [NR-1:0] m;
        m = '0;
        for (int i = 0; i < NR; i++) if (i < k) m[i] = 1'b1;
        return m;
    endfunction

    // Model: phase, current rail and a wait counter, stepped by the sequencing rules.
    always @(posedge clk or posedge rst) begin : model
        int ph, cur, cnt, frail, lost;
        if (rst) begin
            m_ph <= P_OFF; m_cur <= 0; m_cnt <= 0; m_frail <= 0;
        end else begin
            ph = m_ph; cur = m_cur; cnt = m_cnt; frail = m_frail;
            lost = -1;
            if (ph == P_RAMP || ph == P_HOLD || ph == P_ON)
                for (int j = 0; j < NR; j++)
                    if (lost < 0 && (j < cur || (j == cur && ph != P_RAMP)) && !rail_pg[j])
                        lost = j;
            if (lost >= 0) begin
                ph = P_FLT; frail = lost;
            end else if ((ph == P_RAMP || ph == P_HOLD || ph == P_ON) && !pwr_on_req) begin
                ph = P_DOWN; cnt = 0;
            end else begin
                case (ph)
                    P_OFF: if (pwr_on_req) begin ph = P_RAMP; cur = 0; cnt = 0; end
                    P_RAMP: begin
                        if (rail_pg[cur]) begin ph = P_HOLD; cnt = 0; end
                        else if (cnt >= int'(timeout_cycles)) begin ph = P_FLT; frail = cur; end
                        else cnt = (cnt < 65535) ? cnt + 1 : cnt;
                    end
                    P_HOLD: begin
                        if (cnt == int'(settle_cycles)) begin
                            cnt = 0;
                            if (cur == NR - 1) ph = P_ON;
                            else begin ph = P_RAMP; cur = cur + 1; end
                        end else cnt = (cnt < 65535) ? cnt + 1 : cnt;
                    end
                    P_DOWN: begin
                        if (!rail_pg[cur] || cnt >= int'(timeout_cycles)) begin
                            cnt = 0;
                            if (cur == 0) ph = P_OFF;
                            else cur = cur - 1;
                        end else cnt = (cnt < 65535) ? cnt + 1 : cnt;
                    end
                    P_FLT: if (fault_clr && !pwr_on_req) begin
                        ph = P_OFF; cur = 0; cnt = 0; frail = 0;
                    end
                    default: ;
                endcase
            end
            m_ph <= ph; m_cur <= cur; m_cnt <= cnt; m_frail <= frail;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Continuous comparison against the model.
    always @(negedge clk) begin : compare
        logic [NR-1:0] e_en;
        case (m_ph)
            P_RAMP, P_HOLD: e_en = low_mask(m_cur + 1);
            P_ON:           e_en = low_mask(NR);
            P_DOWN:         e_en = low_mask(m_cur);
            default:        e_en = '0;
        endcase
        check("model rail_en", 32'(rail_en), 32'(e_en));
        check("model all_good", 32'(all_good), 32'(m_ph == P_ON));
        check("model busy", 32'(busy), 32'(m_ph == P_RAMP || m_ph == P_HOLD || m_ph == P_DOWN));
        check("model fault", 32'(fault), 32'(m_ph == P_FLT));
        check("model fault_rail", 32'(fault_rail), (m_ph == P_FLT) ? 32'(m_frail) : 32'd0);
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        tick(2);
        check("reset rail_en", 32'(rail_en), 32'h0);
        check("reset busy", 32'(busy), 32'h0);
        rst = 1'b0;
        tick(2);

        // Power-up ramp: one rail every 6 cycles.
        pwr_on_req = 1'b1;
        tick(1);  check("up rail_en E0", 32'(rail_en), 32'h1);
                  check("up busy E0", 32'(busy), 32'h1);
        tick(6);  check("up rail_en E6", 32'(rail_en), 32'h3);
        tick(6);  check("up rail_en E12", 32'(rail_en), 32'h7);
        tick(6);  check("up rail_en E18", 32'(rail_en), 32'hf);
        tick(5);  check("up all_good E23", 32'(all_good), 32'h0);
        tick(1);  check("up all_good E24", 32'(all_good), 32'h1);
                  check("up busy E24", 32'(busy), 32'h0);

        // Power-down: one rail every 2 cycles as power-good falls.
        pwr_on_req = 1'b0;
        tick(1);  check("down rail_en D0", 32'(rail_en), 32'h7);
                  check("down all_good D0", 32'(all_good), 32'h0);
        tick(2);  check("down rail_en D2", 32'(rail_en), 32'h3);
        tick(2);  check("down rail_en D4", 32'(rail_en), 32'h1);
        tick(2);  check("down rail_en D6", 32'(rail_en), 32'h0);
                  check("down busy D6", 32'(busy), 32'h1);
        tick(2);  check("down busy D8", 32'(busy), 32'h0);
        tick(2);

        // Timeout on rail 2.
        stuck_low = 4'b0100;
        pwr_on_req = 1'b1;
        tick(23); check("tmo fault E22", 32'(fault), 32'h0);
                  check("tmo rail_en E22", 32'(rail_en), 32'h7);
        tick(1);  check("tmo fault E23", 32'(fault), 32'h1);
                  check("tmo fault_rail", 32'(fault_rail), 32'h2);
                  check("tmo rail_en E23", 32'(rail_en), 32'h0);
        fault_clr = 1'b1;
        tick(1);  check("tmo clr with req", 32'(fault), 32'h1);
        pwr_on_req = 1'b0;
        tick(1);  check("tmo clr no req", 32'(fault), 32'h0);
                  check("tmo fault_rail clr", 32'(fault_rail), 32'h0);
        fault_clr = 1'b0;
        stuck_low = '0;
        tick(4);

        // Power-good loss on rails 1 and 3 while ON.
        pwr_on_req = 1'b1;
        tick(25); check("loss pre all_good", 32'(all_good), 32'h1);
        force_low = 4'b1010;
        tick(1);  check("loss fault", 32'(fault), 32'h1);
                  check("loss fault_rail", 32'(fault_rail), 32'h1);
                  check("loss rail_en", 32'(rail_en), 32'h0);
                  check("loss all_good", 32'(all_good), 32'h0);
        force_low = '0;
        pwr_on_req = 1'b0;
        fault_clr = 1'b1;
        tick(1);
        fault_clr = 1'b0;
        tick(4);

        // Zero settle: one rail every 3 cycles.
        settle_cycles = 16'd0;
        tick(1);
        pwr_on_req = 1'b1;
        tick(4);  check("s0 rail_en E3", 32'(rail_en), 32'h3);
        tick(9);  check("s0 all_good E12", 32'(all_good), 32'h1);
        // Request re-asserted mid-down is ignored until OFF.
        pwr_on_req = 1'b0;
        tick(4);
        pwr_on_req = 1'b1;
        tick(3);  check("redo rail_en D6", 32'(rail_en), 32'h0);
        tick(2);  check("redo busy D8", 32'(busy), 32'h0);
                  check("redo rail_en D8", 32'(rail_en), 32'h0);
        tick(1);  check("redo rail_en D9", 32'(rail_en), 32'h1);
                  check("redo busy D9", 32'(busy), 32'h1);
        pwr_on_req = 1'b0;
        tick(6);

        // Asynchronous reset during settle of rail 1.
        settle_cycles = 16'd3;
        tick(1);
        pwr_on_req = 1'b1;
        tick(10); check("arst pre rail_en", 32'(rail_en), 32'h3);
        #2 rst = 1'b1;
        #1 check("arst rail_en", 32'(rail_en), 32'h0);
           check("arst busy", 32'(busy), 32'h0);
        pwr_on_req = 1'b0;
        tick(2);
        rst = 1'b0;
        tick(2);
        check("arst post rail_en", 32'(rail_en), 32'h0);
        check("arst post busy", 32'(busy), 32'h0);
        check("arst post all_good", 32'(all_good), 32'h0);
        check("arst post fault", 32'(fault), 32'h0);
        check("arst post fault_rail", 32'(fault_rail), 32'h0);
        tick(2);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/pdn_rail_sequencer.md
Name: pdn_rail_sequencer

Overview:
Supply-side controller that drives the VDD rails feeding the block instances of the power distribution network.
- Power-up: enables rails one at a time in index order, waits for each rail's power-good, then holds a settle delay before the next rail.
- Power-down: runs in reverse order.
- Supervision: timeouts and power-good loss drop all rails at once and latch a fault.
- Sits between the top-level power request and the rail switch enables.

Parameters:
- NUM_RAILS, 8, number of sequenced rails; rail 0 powers first (min 2).
- TMR_W, 16, width of the timeout and settle timer and of its configuration inputs.
- IDX_W, $clog2(NUM_RAILS), width of the rail index and fault_rail.

Ports:
- clk  input  1  single clock; all logic is on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- pwr_on_req  input  1  level request: 1 = rails up, 0 = rails down.
- fault_clr  input  1  one-cycle pulse that clears a latched fault.
- rail_pg  input  NUM_RAILS  per-rail power-good, already synchronous to clk.
- settle_cycles  input  TMR_W  wait after each power-good, in cycles.
- timeout_cycles  input  TMR_W  maximum wait for a power-good transition.
- rail_en  output  NUM_RAILS  per-rail enable, registered.
- all_good  output  1  all rails up and settled.
- busy  output  1  sequencing in progress.
- fault  output  1  fault latched.
- fault_rail  output  IDX_W  index of the rail that caused the fault.

Behaviour:
- Reset (asynchronous):
  - state = OFF, idx = 0, timer = 0.
  - rail_en = 0, all_good = 0, busy = 0, fault = 0, fault_rail = 0.
- States: OFF, UP, SETTLE, ON, DOWN, FAULT.
- Outputs:
  - all_good = (state == ON).
  - busy = (state is UP, SETTLE or DOWN).
  - fault = (state == FAULT).
  - All outputs are registered or decoded directly from state.
- OFF:
  - pwr_on_req = 1 → UP with idx = 0 and timer = 0; rail_en[0] = 1.
  - rail_en[0] is high on the cycle after req is first sampled high.
- UP: timer increments each cycle. Evaluation order per cycle:
  1. rail_pg[idx] = 1 → SETTLE, timer = 0.
  2. Otherwise, timer >= timeout_cycles → FAULT, fault_rail = idx.
- SETTLE:
  - Timer counts up.
  - When timer == settle_cycles: if idx == NUM_RAILS-1 → ON; otherwise idx++, set rail_en[idx+1], timer = 0 → UP.
  - settle_cycles = 0 advances on the first SETTLE cycle.
- Power-good loss (UP, SETTLE, ON):
  - Applies to any rail j already confirmed: j < idx, or j == idx in SETTLE/ON.
  - rail_pg[j] = 0 → FAULT, fault_rail = lowest such j.
  - Power-good loss has priority over every other transition in the same cycle.
- Request drop: pwr_on_req = 0 in UP, SETTLE or ON (and no power-good loss that cycle) → DOWN, timer = 0.
  - idx keeps the highest enabled rail.
  - rail_en[idx] clears on entry.
- DOWN: timer increments each cycle.
  - Step completes when rail_pg[idx] = 0 or timer >= timeout_cycles; a down timeout is not a fault.
  - On step completion: if idx == 0 → OFF; otherwise idx--, clear rail_en[idx-1], timer = 0.
  - pwr_on_req is ignored during DOWN. A re-asserted request is honoured from OFF on the cycle after OFF is reached.
- FAULT:
  - rail_en = 0 on the entry cycle (all rails at once).
  - fault_rail is held.
  - Exit to OFF only when fault_clr = 1 and pwr_on_req = 0 in the same cycle.
  - fault_clr with pwr_on_req = 1 is ignored.
  - fault_rail resets to 0 on exit.
- Invariant: rail_en is always a contiguous mask {rails 0..k}, outside FAULT entry.
- Arithmetic:
  - The timer saturates at all-ones and never wraps.
  - timeout_cycles = 0 means only a power-good already present on the first UP cycle passes.
- settle_cycles and timeout_cycles are sampled every cycle; software changes them only in OFF.
- Reset asserted mid-sequence: rail_en = 0 immediately and asynchronously; state returns to OFF.

Test Plan:
(NUM_RAILS = 4, settle = 3, timeout = 10; each rail's pg rises 2 cycles after its rail_en.)
1. Power-up: req 0→1 → rail_en steps 0001, 0011, 0111, 1111, each step 6 cycles after the previous; all_good = 1 on the cycle after SETTLE of rail 3; busy = 1 throughout the ramp.
2. Power-down from ON: req 1→0 → rail_en steps 0111, 0011, 0001, 0000 as each pg falls; then OFF, busy = 0, all_good drops on the first DOWN cycle.
3. Timeout: rail 2 pg held low → 11 cycles after rail_en[2] rises, fault = 1, fault_rail = 2, rail_en = 0000; fault_clr with req = 1 → stays in FAULT; fault_clr with req = 0 → OFF, fault = 0.
4. Power-good loss: in ON, force rail_pg[1] and rail_pg[3] low in the same cycle → next cycle fault = 1, fault_rail = 1, rail_en = 0000, all_good = 0.
5. Boundaries: settle = 0 → each rail advances on the cycle after its pg. Request re-asserted mid-DOWN → completes to 0000, then restarts the up-sequence from OFF.
6. Asynchronous reset during SETTLE of rail 1 → rail_en = 0000 without a clock edge; after release, state is OFF and all outputs are 0.
